bus_rr_arbiter: RTL and testbench

- Round-robin arbiter and packet router that shares the single broadcast bus between `drvrs` device FIFOs.
- Selects one pending source and pops its head packet.
- Decodes the 8-bit destination header and pushes the packet to the target device's input FIFO, or to all devices except the source for a broadcast.
- Sits between the per-device FIFOs (`bus_if`) and the devices; it replaces ad-hoc arbitration with a fair, backpressure-aware sequencer.

---
 rtl/bus_arb_pkg.sv | 17 +
 rtl/bus_rr_arbiter_rr_pick.sv | 31 +++
 rtl/bus_rr_arbiter.sv | 115 +++++++++++
 tb/tb_bus_rr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter/router.
package bus_arb_pkg;

  typedef enum logic [1:0] {IDLE, POP, ROUTE, PUSH} state_t;

  localparam logic [7:0] BCAST_ID = 8'hFF;
  localparam int         HDR_W    = 8;
  localparam int         PKT_MAX  = 256;

  // The destination header occupies the top HDR_W bits of a w-bit packet.
  function automatic logic [HDR_W-1:0] dest_of(input logic [PKT_MAX-1:0] pkt, input int w);
    logic [PKT_MAX-1:0] s;
    s = pkt >> (w - HDR_W);
    return s[HDR_W-1:0];
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1,
// wrapping modulo drvrs.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0] req,
  input  logic [HDR_W-1:0] last,
  output logic [HDR_W-1:0] gnt_idx,
  output logic             any
);

  int               start;
  logic [drvrs-1:0] rot;

  // Rotate so the highest-priority candidate lands at bit 0; lowest set bit wins.
  always_comb begin
    start   = (int'(last) + 1) % drvrs;
    rot     = drvrs'({req, req} >> start);
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = drvrs - 1; i >= 0; i--) begin
      if (rot[i]) begin
        gnt_idx = HDR_W'((start + i) % drvrs);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter and packet router for the shared broadcast bus.
// Define BUS_ARB_STATS_EN to add saturating drop_cnt/stall_cnt outputs.
//
// state | meaning
// IDLE  | waiting for any pending source; arbitrates and registers grant_id
// POP   | pop strobe to granted source, head packet captured into pkt_q
// ROUTE | decode destination; drop invalid, wait while any target is full
// PUSH  | push strobe(s) to target(s) with packet on D_push
module bus_rr_arbiter #(
  parameter int         pckg_sz  = 24,
  parameter int         drvrs    = 4,
  parameter logic [7:0] BCAST_ID = bus_arb_pkg::BCAST_ID
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  input  logic [drvrs-1:0]         full,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic [7:0]               grant_id,
  output logic                     busy
`ifdef BUS_ARB_STATS_EN
  ,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              stall_cnt
`endif
);
  import bus_arb_pkg::*;

  state_t             state;
  logic [pckg_sz-1:0] pkt_q;
  logic [HDR_W-1:0]   dest;
  logic [HDR_W-1:0]   pick_idx;
  logic               pick_any;
  logic [drvrs-1:0]   one;
  logic [drvrs-1:0]   mask;
  logic               drop;
  logic               blocked;

  rr_pick #(.drvrs(drvrs)) u_pick (
    .req     (pndng),
    .last    (grant_id),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign one = drvrs'(1);

  // A packet addressed back to its own source is treated as invalid.
  always_comb begin
    dest = dest_of(PKT_MAX'(pkt_q), pckg_sz);
    mask = '0;
    drop = 1'b0;
    if (dest == grant_id)        drop = 1'b1;
    else if (int'(dest) < drvrs) mask = one << dest;
    else if (dest == BCAST_ID)   mask = ~(one << grant_id);
    else                         drop = 1'b1;
    blocked = (mask & full) != '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      grant_id <= 8'(drvrs - 1);
      pkt_q    <= '0;
    end else begin
      pop  <= '0;
      push <= '0;
      case (state)
        IDLE: if (pick_any) begin
          grant_id <= pick_idx;
          pop      <= one << pick_idx;
          state    <= POP;
        end
        POP: begin
          pkt_q <= pckg_sz'(D_pop >> (int'(grant_id) * pckg_sz));
          state <= ROUTE;
        end
        ROUTE: begin
          if (drop) state <= IDLE;
          else if (!blocked) begin
            push   <= mask;
            D_push <= pkt_q;
            state  <= PUSH;
          end
        end
        PUSH:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef BUS_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt  <= '0;
      stall_cnt <= '0;
    end else if (state == ROUTE) begin
      if (drop) begin
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (blocked && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: queue-backed source FIFOs, transaction-level
// round-robin/routing model, directed scenarios followed by randomized traffic.
module tb_bus_rr_arbiter;
  localparam int N = 4;
  localparam int W = 24;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   pndng = '0;
  logic [N*W-1:0] D_pop = '0;
  logic [N-1:0]   full = '0;
  logic [N-1:0]   pop;
  logic [N-1:0]   push;
  logic [W-1:0]   D_push;
  logic [7:0]     grant_id;
  logic           busy;

  typedef struct packed {
    logic [N-1:0] mask;
    logic [W-1:0] data;
  } exp_t;

  logic [W-1:0] src_q [N][$];
  exp_t         exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;
  int n_pushes = 0;
  int last_src = N - 1;
  bit pend_pop = 1'b0;
  int pend_src = 0;
  logic [N-1:0] pndng_edge = '0;
  logic [N-1:0] full_edge  = '0;

  bus_rr_arbiter #(.pckg_sz(W), .drvrs(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .full     (full),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: first pending source scanning upward from last+1, modulo N.
  function automatic int rr_expect(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (p[c]) return c;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit route(input logic [W-1:0] pk, input int s, output exp_t x);
    int d;
    d = int'(pk[W-1 -: 8]);
    x.data = pk;
    x.mask = '0;
    if (d < N && d != s) begin
      x.mask = N'(1 << d);
      return 1'b1;
    end
    if (d == 8'hFF) begin
      x.mask = ~N'(1 << s);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_pkt();
    int r;
    logic [7:0] d;
    r = $urandom_range(0, 9);
    if (r <= 5)      d = 8'(r % N);
    else if (r <= 7) d = 8'hFF;
    else             d = 8'($urandom_range(N, 254));
    return {d, 16'($urandom)};
  endfunction

  // Source FIFO model: first-word-fall-through view of each queue.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      pndng[i] = (src_q[i].size() != 0);
      D_pop[i*W +: W] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
    end
  end

  always @(posedge clk) begin
    pndng_edge <= pndng;
    full_edge  <= full;
  end

  // Monitor: arbitration and routing checked against the model.
  always @(negedge clk) begin
    int s, e;
    logic [W-1:0] pk;
    exp_t x;
    if (!reset) begin
      last_src = N - 1;
      exp_q.delete();
      pend_pop = 1'b0;
    end else begin
      if (pend_pop) begin
        if (src_q[pend_src].size() > 0) void'(src_q[pend_src].pop_front());
        pend_pop = 1'b0;
      end
      if (pop != '0) begin
        n_pops++;
        chk("pop_onehot", 32'($onehot(pop)), 1);
        chk("pop_push_excl", 32'(push == '0), 1);
        s = idx_of(pop);
        e = rr_expect(pndng_edge, last_src);
        chk("rr_grant", s, e);
        chk("grant_id", 32'(grant_id), e);
        chk("prev_done", exp_q.size(), 0);
        last_src = s;
        if (src_q[s].size() == 0) chk("pop_empty_src", s, -1);
        else begin
          pk = src_q[s][0];
          if (route(pk, s, x)) exp_q.push_back(x);
          pend_pop = 1'b1;
          pend_src = s;
        end
      end
      if (push != '0) begin
        n_pushes++;
        chk("push_vs_full", 32'(push & full_edge), 0);
        if (exp_q.size() == 0) chk("unexpected_push", 32'(push), 0);
        else begin
          x = exp_q.pop_front();
          chk("push_mask", 32'(push), 32'(x.mask));
          chk("push_data", 32'(D_push), 32'(x.data));
        end
      end
    end
  end

  task automatic wait_pop(output logic [N-1:0] p);
    p = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pop != '0) begin
        p = pop;
        return;
      end
    end
    chk("pop_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    full = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
          src_q[2].size() == 0 && src_q[3].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 32'(ok), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] p;
    int rr_order[6] = '{0, 1, 3, 0, 1, 3};
    int pops0, pushes0, s;

    // Reset held with all sources pending.
    for (int i = 0; i < N; i++) src_q[i].push_back({8'((i + 1) % N), 16'(i)});
    repeat (3) @(negedge clk);
    chk("rst_pop", 32'(pop), 0);
    chk("rst_push", 32'(push), 0);
    chk("rst_grant_id", 32'(grant_id), 3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_d_push", 32'(D_push), 0);
    reset = 1'b1;
    wait_pop(p);
    chk("first_pop", 32'(p), 32'h1);
    drain();

    // Round-robin with sources 0,1,3 continuously pending.
    for (int r = 0; r < 3; r++) begin
      src_q[0].push_back({8'h01, 16'(r)});
      src_q[1].push_back({8'h02, 16'(r)});
      src_q[3].push_back({8'h00, 16'(r)});
    end
    for (int k = 0; k < 6; k++) begin
      wait_pop(p);
      chk("rr_order", 32'(p), 32'(1 << rr_order[k]));
    end
    drain();

    // Unicast latency.
    @(negedge clk);
    src_q[1].push_back(24'h02_ABCD);
    @(negedge clk);
    chk("uni_pop", 32'(pop), 32'h2);
    @(negedge clk);
    chk("uni_no_push_yet", 32'(push), 0);
    @(negedge clk);
    chk("uni_push", 32'(push), 32'h4);
    chk("uni_data", 32'(D_push), 32'h02_ABCD);
    drain();

    // Broadcast held by backpressure on one target.
    full = 4'b0001;
    src_q[2].push_back(24'hFF_1234);
    wait_pop(p);
    chk("bc_pop", 32'(p), 32'h4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bc_stall", 32'(push), 0);
    end
    full = '0;
    @(negedge clk);
    chk("bc_push", 32'(push), 32'hB);
    chk("bc_data", 32'(D_push), 32'hFF_1234);
    @(negedge clk);
    chk("bc_single", 32'(push), 0);
    drain();

    // Invalid destinations are dropped.
    pops0 = n_pops;
    pushes0 = n_pushes;
    src_q[1].push_back(24'h07_0000);
    src_q[1].push_back(24'h01_0000);
    repeat (14) @(negedge clk);
    chk("inv_pops", n_pops - pops0, 2);
    chk("inv_pushes", n_pushes - pushes0, 0);
    chk("inv_idle", 32'(busy), 0);
    drain();

    // Reset during ROUTE aborts the transfer.
    full = 4'hF;
    src_q[0].push_back(24'h02_5555);
    wait_pop(p);
    chk("mid_pop", 32'(p), 32'h1);
    src_q[0].push_back(24'h03_8888);
    src_q[2].push_back(24'h01_7777);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_pop", 32'(pop), 0);
    chk("mid_rst_push", 32'(push), 0);
    chk("mid_rst_d_push", 32'(D_push), 0);
    chk("mid_rst_grant", 32'(grant_id), 3);
    chk("mid_rst_busy", 32'(busy), 0);
    full = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_pop(p);
    chk("mid_restart_dev0", 32'(p), 32'h1);
    drain();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      full = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, N - 1);
        if (src_q[s].size() < 4) src_q[s].push_back(rand_pkt());
      end
    end
    drain();
    chk("final_scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
